blur_frame_ctrl: RTL

- Frame-level sequencer and flow controller for the 3x3 box blur datapath (4-line-buffer pipeline plus MAC).
- Sits between an upstream valid/ready pixel stream and the blur datapath's valid-only pixel input.
- Uses line-buffer credits to throttle input so a line buffer is never overwritten before it is read.
- Counts rows and output pixels, and signals frame completion.

---
 rtl/blur_frame_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/blur_frame_ctrl.sv
// Frame sequencer and credit-based flow controller for the 3x3 box blur datapath.
// Define BLUR_FRAME_CTRL_STATS_EN to add the stall_cycles output.
module blur_frame_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned IMG_WIDTH   = 512,
    parameter int unsigned IMG_HEIGHT  = 512,
    parameter int unsigned NUM_BUF     = 4,
    parameter int unsigned OUT_PER_ROW = 512,
    localparam int unsigned RowW       = $clog2(IMG_HEIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    input  logic [DATA_WIDTH-1:0] s_pixel,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] blur_pixel,
    output logic                  blur_valid,
    input  logic                  blur_line_rd,
    input  logic                  blur_out_valid,
    output logic [RowW-1:0]       rows_in,
    output logic [RowW-1:0]       rows_out,
    output logic                  credit_err
`ifdef BLUR_FRAME_CTRL_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int unsigned ColW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned CrdW     = $clog2(NUM_BUF + 1);
    localparam int unsigned OutTotal = (IMG_HEIGHT - 2) * OUT_PER_ROW;
    localparam int unsigned OutW     = $clog2(OutTotal + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] rows_in_q, rows_in_d;
    logic [RowW-1:0] rows_out_q, rows_out_d;
    logic [OutW-1:0] out_cnt_q, out_cnt_d;
    logic [CrdW-1:0] credits_q, credits_d;
    logic            credit_err_q, credit_err_d;
    logic            hs;
    logic            line_done;
    logic            counting;

    assign s_ready    = (state_q == StRun) && (credits_q != '0) &&
                        (rows_in_q < RowW'(IMG_HEIGHT));
    assign hs         = s_valid && s_ready;
    assign line_done  = hs && (col_q == ColW'(IMG_WIDTH - 1));
    assign counting   = (state_q == StRun) || (state_q == StDrain);
    assign blur_pixel = s_pixel;
    assign blur_valid = hs;
    assign busy       = counting;
    assign frame_done = (state_q == StDone);
    assign rows_in    = rows_in_q;
    assign rows_out   = rows_out_q;
    assign credit_err = credit_err_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        rows_in_d    = rows_in_q;
        rows_out_d   = rows_out_q;
        out_cnt_d    = out_cnt_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;

        // A freed buffer and a newly filled one in the same cycle cancel out.
        if (line_done && !blur_line_rd) begin
            credits_d = credits_q - CrdW'(1);
        end else if (!line_done && blur_line_rd) begin
            if (credits_q == CrdW'(NUM_BUF)) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CrdW'(1);
            end
        end

        if (counting) begin
            if (blur_line_rd && (rows_out_q != RowW'(IMG_HEIGHT))) begin
                rows_out_d = rows_out_q + RowW'(1);
            end
            if (blur_out_valid && (out_cnt_q != OutW'(OutTotal))) begin
                out_cnt_d = out_cnt_q + OutW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    col_d      = '0;
                    rows_in_d  = '0;
                    rows_out_d = '0;
                    out_cnt_d  = '0;
                    credits_d  = CrdW'(NUM_BUF);
                end
            end
            StRun: begin
                if (hs) begin
                    if (line_done) begin
                        col_d     = '0;
                        rows_in_d = rows_in_q + RowW'(1);
                        if (rows_in_q == RowW'(IMG_HEIGHT - 1)) begin
                            state_d = StDrain;
                        end
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
            StDrain: begin
                if ((rows_out_q == RowW'(IMG_HEIGHT - 2)) && (out_cnt_q == OutW'(OutTotal))) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            col_q        <= '0;
            rows_in_q    <= '0;
            rows_out_q   <= '0;
            out_cnt_q    <= '0;
            credits_q    <= CrdW'(NUM_BUF);
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            rows_in_q    <= rows_in_d;
            rows_out_q   <= rows_out_d;
            out_cnt_q    <= out_cnt_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

`ifdef BLUR_FRAME_CTRL_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == StRun) && s_valid && !s_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if ((state_q == StIdle) && start) begin
            stall_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
